fwd_mux_reg: RTL and testbench
==============================

# fwd_mux_reg

Parametrised N-way operand selector with a registered output stage, for the pipelined CPU's forwarding and bypass paths (ALU operand A/B, store data, branch compare). Each cycle it selects one of N WIDTH-bit channels and captures the result in an output register. The register carries a valid bit and supports pipeline stall (hold) and flush (bubble). Out-of-range selects fall back to channel 0, and an optional checker counts them.

## Interface

**Parameters**
- `WIDTH`, default 32: data width of each channel and of the output.
- `N`, default 3: channel count; legal range 2..16.
- `SELW`, default 2: select width; must satisfy 2^SELW ≥ N.

**Ports** (clock and reset first)
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, N*WIDTH: flattened channels; channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `sel`, input, SELW: channel select.
- `in_valid`, input, 1: the current selection carries a real instruction.
- `stall`, input, 1: hold all registered outputs.
- `flush`, input, 1: insert a bubble.
- `dout`, output, WIDTH: registered selected data.
- `out_valid`, output, 1: `dout` holds a valid operand.
- `sel_q`, output, SELW: the registered effective select (after fallback), for debug and trace.
- `illegal_cnt`, output, 8: saturating illegal-select count (present only with the macro; otherwise tied to 0).

## Operation
- Effective select: `esel = (sel < N) ? sel : 0`. Channel 0 is the fallback for any code ≥ N, including unused codes when N < 2^SELW.
- Per-edge priority: reset > flush > stall > load.
  - **reset**: `dout`=0, `out_valid`=0, `sel_q`=0, `illegal_cnt`=0.
  - **flush** (overrides stall): `dout`=0, `out_valid`=0, `sel_q`=0. Counter unchanged.
  - **stall**, without flush: all outputs hold their values.
  - **load**: `dout`=`din[esel]`, `out_valid`=`in_valid`, `sel_q`=`esel`.
- Data with `in_valid`=0 still loads into `dout`. Consumers must qualify `dout` with `out_valid`.
- No arithmetic is performed on data. The select comparison is unsigned.

## Timing
- Latency is 1 cycle: inputs sampled at edge t appear on the outputs after edge t.
- The selection path is purely combinational up to the output register. There is no combinational input-to-output path.
- Stall held for k cycles keeps the outputs constant for k cycles. The first edge with stall deasserted loads the then-current inputs.
- Stall and flush asserted together: flush takes effect.
- Reset asserted mid-stream: outputs are zero after the next edge, regardless of stall or flush.
- All outputs are 0 from the first edge with reset high until the first load edge after reset deasserts.

## Configuration
- Macro: `FWD_MUX_SEL_CHECK_EN`.
- **Defined**: `illegal_cnt` increments by 1 on each load edge where `in_valid`=1 and `sel` ≥ N.
  - Saturates at 255.
  - Does not increment on stall, flush, reset, or `in_valid`=0 edges.
  - Cleared only by reset.
- **Undefined**: the checker logic is removed. `illegal_cnt` is constant 0. Fallback-to-channel-0 behaviour is unchanged.

## Test plan
- **Basic select.** Setup: N=3, WIDTH=32; din ch0=0x11111111, ch1=0x22222222, ch2=0x33333333.
  - Stimulus: sel 0,1,2 with in_valid=1.
  - Required: dout is 0x11111111, 0x22222222, 0x33333333 one cycle after each; out_valid=1; sel_q=0,1,2.
- **Illegal select.** Setup: macro defined.
  - Stimulus: sel=3 with in_valid=1.
  - Required: dout=0x11111111; sel_q=0; illegal_cnt 0→1.
  - Stimulus: repeat for 300 cycles.
  - Required: illegal_cnt=255.
  - Stimulus: sel=3 with in_valid=0.
  - Required: illegal_cnt unchanged.
- **Stall hold.** Setup: load ch1 (dout=0x22222222).
  - Stimulus: assert stall for 3 cycles while switching sel to 2.
  - Required: dout stays 0x22222222 for all 3 cycles.
  - Stimulus: release stall.
  - Required: dout=0x33333333 after the next edge.
- **Flush versus stall.** Setup: out_valid=1.
  - Stimulus: assert stall and flush together.
  - Required: after the edge, dout=0, out_valid=0, sel_q=0.
- **Reset mid-stream.** Stimulus: during a load sequence, assert reset with stall=1.
  - Required: all outputs 0 after the edge, including illegal_cnt.
  - Stimulus: deassert reset.
  - Required: loading resumes next cycle.
- **Parametrised configuration.** Setup: N=5, SELW=3, WIDTH=16.
  - Stimulus: sel=4.
  - Required: dout is ch4 data.
  - Stimulus: sel=5, 6, 7.
  - Required: dout is ch0 data each time.
  - Setup: macro undefined.
  - Required: illegal_cnt remains 0 throughout.

Source files
------------

// File: rtl/fwd_mux_reg.sv
// -----------------------------------------------------------------------------
// fwd_mux_reg
//
// N-way operand selector with a registered output stage, used on the CPU's
// forwarding/bypass paths (ALU operands, store data, branch compare). Each
// cycle one of N WIDTH-bit channels is selected and captured in the output
// register along with a valid bit and the effective select. The register
// supports stall (hold) and flush (bubble). Select codes >= N fall back to
// channel 0.
//
// Optional feature macro: FWD_MUX_SEL_CHECK_EN
//   defined   : illegal_cnt counts load edges with in_valid=1 and sel >= N,
//               saturating at 255, cleared only by reset.
//   undefined : checker removed, illegal_cnt is constant 0.
//
// Ports
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous, active-high reset
//   din          in   N*WIDTH     flattened channels, ch k at [k*WIDTH +: WIDTH]
//   sel          in   SELW        channel select
//   in_valid     in   1           selection carries a real instruction
//   stall        in   1           hold all registered outputs
//   flush        in   1           insert a bubble (overrides stall)
//   dout         out  WIDTH       registered selected data
//   out_valid    out  1           dout holds a valid operand
//   sel_q        out  SELW        registered effective select (after fallback)
//   illegal_cnt  out  8           saturating illegal-select count
//
// Per-edge priority: reset > flush > stall > load.
// -----------------------------------------------------------------------------
module fwd_mux_reg #(
   parameter int WIDTH = 32,
   parameter int N     = 3,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   din,
   input  logic [SELW-1:0]      sel,
   input  logic                 in_valid,
   input  logic                 stall,
   input  logic                 flush,
   output logic [WIDTH-1:0]     dout,
   output logic                 out_valid,
   output logic [SELW-1:0]      sel_q,
   output logic [7:0]           illegal_cnt
);

   // Channel count widened by one bit so N = 2^SELW is representable and the
   // range compare stays unsigned.
   localparam logic [SELW:0] N_W = (SELW+1)'(N);

   logic                in_range_s;
   logic [SELW-1:0]     esel_s;
   logic [WIDTH-1:0]    mux_s;
   logic                load_s;

   logic [WIDTH-1:0]    dout_r;
   logic                out_valid_r;
   logic [SELW-1:0]     sel_q_r;

   assign in_range_s = ({1'b0, sel} < N_W);
   assign load_s     = !flush && !stall;

   // Effective select: out-of-range codes fall back to channel 0.
   always_comb begin
      esel_s = {SELW{1'b0}};
      if (in_range_s) begin
         esel_s = sel;
      end else begin
         esel_s = {SELW{1'b0}};
      end
   end

   // Channel multiplexer; esel_s is always < N so exactly one term matches.
   always_comb begin
      mux_s = {WIDTH{1'b0}};
      for (int k = 0; k < N; k++) begin
         mux_s = (esel_s == SELW'(k)) ? din[k*WIDTH +: WIDTH] : mux_s;
      end
   end

   // Output register: reset, then flush (bubble), then stall (hold), then load.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_r      <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         sel_q_r     <= {SELW{1'b0}};
      end else if (flush) begin
         dout_r      <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         sel_q_r     <= {SELW{1'b0}};
      end else if (stall) begin
         dout_r      <= dout_r;
         out_valid_r <= out_valid_r;
         sel_q_r     <= sel_q_r;
      end else begin
         // Data loads even when in_valid=0; consumers qualify with out_valid.
         dout_r      <= mux_s;
         out_valid_r <= in_valid;
         sel_q_r     <= esel_s;
      end
   end

   assign dout      = dout_r;
   assign out_valid = out_valid_r;
   assign sel_q     = sel_q_r;

`ifdef FWD_MUX_SEL_CHECK_EN
   logic       illegal_load_s;
   logic [7:0] illegal_cnt_r;

   // Only a real instruction on a load edge with an out-of-range code counts.
   assign illegal_load_s = load_s && in_valid && !in_range_s;

   // Saturating illegal-select counter, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_cnt_r <= 8'd0;
      end else if (illegal_load_s && (illegal_cnt_r != 8'hFF)) begin
         illegal_cnt_r <= illegal_cnt_r + 8'd1;
      end else begin
         illegal_cnt_r <= illegal_cnt_r;
      end
   end

   assign illegal_cnt = illegal_cnt_r;
`else
   logic unused_load_s;

   assign unused_load_s = load_s;
   assign illegal_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_fwd_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_fwd_mux_reg
//
// Two instances: A (N=3, SELW=2, WIDTH=32) and B (N=5, SELW=3, WIDTH=16) share
// the control inputs. Stimulus computes expected outputs from the behavioural
// rules and pushes them into a queue; a monitor pops one entry per edge and
// compares all outputs of both instances.
// -----------------------------------------------------------------------------
module tb_fwd_mux_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, in_valid, stall, flush;
   logic [95:0] din_a;
   logic [1:0]  sel_a;
   logic [79:0] din_b;
   logic [2:0]  sel_b;

   logic [31:0] dout_a;
   logic        ov_a;
   logic [1:0]  selq_a;
   logic [7:0]  cnt_a;
   logic [15:0] dout_b;
   logic        ov_b;
   logic [2:0]  selq_b;
   logic [7:0]  cnt_b;

   fwd_mux_reg #(.WIDTH(32), .N(3), .SELW(2)) dut_a (
      .clk(clk), .reset(reset), .din(din_a), .sel(sel_a),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .dout(dout_a), .out_valid(ov_a), .sel_q(selq_a), .illegal_cnt(cnt_a)
   );

   fwd_mux_reg #(.WIDTH(16), .N(5), .SELW(3)) dut_b (
      .clk(clk), .reset(reset), .din(din_b), .sel(sel_b),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .dout(dout_b), .out_valid(ov_b), .sel_q(selq_b), .illegal_cnt(cnt_b)
   );

   // Channel data as arrays; packed into the flattened buses by step().
   logic [31:0] ch_a [3];
   logic [15:0] ch_b [5];

   typedef struct {
      logic [31:0] dout_a;
      logic        ov_a;
      logic [1:0]  selq_a;
      logic [7:0]  cnt_a;
      logic [15:0] dout_b;
      logic        ov_b;
      logic [2:0]  selq_b;
      logic [7:0]  cnt_b;
   } exp_t;

   exp_t q[$];
   exp_t m;          // reference model state (what outputs should become)
   exp_t e_mon;      // monitor's popped entry

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // Reference model: apply the per-edge rules to the current inputs.
   task automatic model_edge();
      int ea, eb;
      ea = (int'(sel_a) < 3) ? int'(sel_a) : 0;
      eb = (int'(sel_b) < 5) ? int'(sel_b) : 0;
      if (reset) begin
         m.dout_a = 32'd0; m.ov_a = 1'b0; m.selq_a = 2'd0; m.cnt_a = 8'd0;
         m.dout_b = 16'd0; m.ov_b = 1'b0; m.selq_b = 3'd0; m.cnt_b = 8'd0;
      end else if (flush) begin
         m.dout_a = 32'd0; m.ov_a = 1'b0; m.selq_a = 2'd0;
         m.dout_b = 16'd0; m.ov_b = 1'b0; m.selq_b = 3'd0;
      end else if (!stall) begin
         m.dout_a = ch_a[ea]; m.ov_a = in_valid; m.selq_a = 2'(ea);
         m.dout_b = ch_b[eb]; m.ov_b = in_valid; m.selq_b = 3'(eb);
`ifdef FWD_MUX_SEL_CHECK_EN
         if (in_valid && int'(sel_a) >= 3 && m.cnt_a < 8'd255) m.cnt_a = m.cnt_a + 8'd1;
         if (in_valid && int'(sel_b) >= 5 && m.cnt_b < 8'd255) m.cnt_b = m.cnt_b + 8'd1;
`endif
      end
   endtask

   // Apply inputs, predict, push expectation, advance one edge.
   task automatic step();
      din_a = {ch_a[2], ch_a[1], ch_a[0]};
      din_b = {ch_b[4], ch_b[3], ch_b[2], ch_b[1], ch_b[0]};
      model_edge();
      q.push_back(m);
      @(posedge clk);
      #2;
   endtask

   // Monitor: registered outputs are compared 1 time unit after each edge.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e_mon = q.pop_front();
         chk("dout_a",   dout_a, e_mon.dout_a);
         chk("valid_a",  32'(ov_a), 32'(e_mon.ov_a));
         chk("sel_q_a",  32'(selq_a), 32'(e_mon.selq_a));
         chk("illcnt_a", 32'(cnt_a), 32'(e_mon.cnt_a));
         chk("dout_b",   32'(dout_b), 32'(e_mon.dout_b));
         chk("valid_b",  32'(ov_b), 32'(e_mon.ov_b));
         chk("sel_q_b",  32'(selq_b), 32'(e_mon.selq_b));
         chk("illcnt_b", 32'(cnt_b), 32'(e_mon.cnt_b));
      end
   end

   initial begin
      m = '{default: '0};
      reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      sel_a = 2'd0; sel_b = 3'd0;
      ch_a[0] = 32'h11111111; ch_a[1] = 32'h22222222; ch_a[2] = 32'h33333333;
      ch_b[0] = 16'h1111; ch_b[1] = 16'h2222; ch_b[2] = 16'h3333;
      ch_b[3] = 16'h4444; ch_b[4] = 16'h5555;
      step(); step();
      reset = 1'b0;

      // Basic select on both instances.
      in_valid = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel_a = 2'(s); sel_b = 3'(s);
         step();
      end
      // Upper and out-of-range codes on B.
      for (int s = 3; s < 8; s++) begin
         sel_b = 3'(s);
         step();
      end

      // Illegal select and saturation.
      sel_a = 2'd3; sel_b = 3'd7;
      step();
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      step(); step();
      in_valid = 1'b1;

      // Stall hold while select changes, then release.
      sel_a = 2'd1; sel_b = 3'd1;
      step();
      stall = 1'b1; sel_a = 2'd2; sel_b = 3'd4;
      step(); step(); step();
      stall = 1'b0;
      step(); step();

      // Flush together with stall while out_valid=1.
      stall = 1'b1; flush = 1'b1;
      step();
      stall = 1'b0; flush = 1'b0;
      step();

      // Reset mid-stream with stall asserted.
      sel_a = 2'd3; sel_b = 3'd6;
      step(); step(); step();
      reset = 1'b1; stall = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0; sel_a = 2'd2; sel_b = 3'd3;
      step(); step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 3; k++) ch_a[k] = $urandom;
         for (int k = 0; k < 5; k++) ch_b[k] = 16'($urandom);
         sel_a    = 2'($urandom_range(0, 3));
         sel_b    = 3'($urandom_range(0, 7));
         in_valid = 1'($urandom_range(0, 1));
         stall    = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         reset    = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      step();

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
